spi_cmd_decoder: RTL and testbench



---
 rtl/spi_cmd_decoder.sv | 135 +++++++++++++
 tb/tb_spi_cmd_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI command layer: turns 2-byte frames from the byte bridge into register read/write strobes.
// Optional AUTO_INC_EN: burst frames with an auto-incrementing address until cs_n deasserts.
module spi_cmd_decoder #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_cs_meta, r_cs_sync;
    logic              r_rw, w_rw_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic              r_read, w_read_next;
    logic              r_write, w_write_next;
    logic [7:0]        r_data_write, w_data_write_next;
    logic [7:0]        r_data_out, w_data_out_next;

`ifdef AUTO_INC_EN
    // Write bursts use the command address for the first data byte, then increment.
    logic              r_first, w_first_next;
    logic [ADDR_W-1:0] w_addr_inc;
    assign w_addr_inc = r_addr + ADDR_W'(1);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_rw_next         = r_rw;
        w_addr_next       = r_addr;
        w_read_next       = 1'b0;
        w_write_next      = 1'b0;
        w_data_write_next = r_data_write;
        w_data_out_next   = r_data_out;
`ifdef AUTO_INC_EN
        w_first_next      = r_first;
`endif
        if (r_read) begin
            w_data_out_next = data_read;
        end

        if (r_cs_sync) begin
            w_state_next    = IDLE;
            w_data_out_next = 8'h00;
        end else if (byte_sync) begin
            case (r_state)
                IDLE: begin
                    w_rw_next    = data_in[7];
                    w_addr_next  = data_in[ADDR_W-1:0];
                    w_state_next = DATA;
`ifdef AUTO_INC_EN
                    w_first_next = 1'b1;
`endif
                    if (data_in[7]) begin
                        w_data_out_next = 8'h00;
                    end else begin
                        w_read_next = 1'b1;
                    end
                end
                DATA: begin
`ifdef AUTO_INC_EN
                    w_first_next = 1'b0;
                    if (r_rw) begin
                        w_write_next      = 1'b1;
                        w_data_write_next = data_in;
                        if (!r_first) begin
                            w_addr_next = w_addr_inc;
                        end
                    end else begin
                        w_read_next = 1'b1;
                        w_addr_next = w_addr_inc;
                    end
`else
                    if (r_rw) begin
                        w_write_next      = 1'b1;
                        w_data_write_next = data_in;
                    end
                    w_state_next = IDLE;
`endif
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_data_write <= 8'h00;
            r_data_out   <= 8'h00;
`ifdef AUTO_INC_EN
            r_first      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_cs_meta    <= cs_n;
            r_cs_sync    <= r_cs_meta;
            r_rw         <= w_rw_next;
            r_addr       <= w_addr_next;
            r_read       <= w_read_next;
            r_write      <= w_write_next;
            r_data_write <= w_data_write_next;
            r_data_out   <= w_data_out_next;
`ifdef AUTO_INC_EN
            r_first      <= w_first_next;
`endif
        end
    end

    assign read       = r_read;
    assign write      = r_write;
    assign addr       = r_addr;
    assign data_write = r_data_write;
    assign data_out   = r_data_out;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: vector table, hand-written corner cases and random frames vs. a frame-level model.
module tb_spi_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [6:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;

    logic [7:0] regmem [0:127];
    assign data_read = regmem[addr];

    spi_cmd_decoder #(.ADDR_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit wr;
        int a;
        int d;
        int cyc;
    } ev_t;

    ev_t  ev_q[$];
    ev_t  exp_q[$];
    logic [7:0] frame_q[$];
    int   time_q[$];

    // Strobe monitor: logs every strobe cycle, and flags simultaneous read/write.
    always @(negedge clk) begin
        if (read === 1'b1 || write === 1'b1) begin
            chk("strobe_exclusive", {31'd0, read & write}, 32'd0);
            ev_q.push_back('{write === 1'b1, int'(addr), int'(data_write), cyc});
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        @(negedge clk);
        data_in   = b;
        byte_sync = 1'b1;
        t         = cyc;
        @(negedge clk);
        byte_sync = 1'b0;
    endtask

    // Frame-level reference: decodes the byte list of one cs_n-low frame into strobes.
    task automatic build_expected();
        int n;
        int a;
        exp_q.delete();
        n = frame_q.size();
`ifdef AUTO_INC_EN
        if (n > 0) begin
            a = int'(frame_q[0]) % 128;
            if (!frame_q[0][7]) exp_q.push_back('{1'b0, a, 0, time_q[0] + 1});
            for (int k = 1; k < n; k++) begin
                if (frame_q[0][7])
                    exp_q.push_back('{1'b1, (a + k - 1) % 128, int'(frame_q[k]), time_q[k] + 1});
                else
                    exp_q.push_back('{1'b0, (a + k) % 128, 0, time_q[k] + 1});
            end
        end
`else
        for (int i = 0; i < n; i += 2) begin
            a = int'(frame_q[i]) % 128;
            if (!frame_q[i][7]) exp_q.push_back('{1'b0, a, 0, time_q[i] + 1});
            if (frame_q[i][7] && (i + 1 < n))
                exp_q.push_back('{1'b1, a, int'(frame_q[i + 1]), time_q[i + 1] + 1});
        end
`endif
    endtask

    task automatic run_frame(input string tag);
        int t;
        int m;
        ev_q.delete();
        time_q.delete();
        cs_n = 1'b0;
        gap(3);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], t);
            time_q.push_back(t);
            gap(7);
        end
        cs_n = 1'b1;
        gap(4);
        build_expected();
        chk({tag, "_event_count"}, ev_q.size(), exp_q.size());
        m = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_kind"}, {31'd0, ev_q[i].wr}, {31'd0, exp_q[i].wr});
            chk({tag, "_addr"}, ev_q[i].a, exp_q[i].a);
            chk({tag, "_cycle"}, ev_q[i].cyc, exp_q[i].cyc);
            if (exp_q[i].wr) chk({tag, "_wdata"}, ev_q[i].d, exp_q[i].d);
        end
        chk({tag, "_dout_cleared"}, data_out, 8'h00);
        $display("frame %s: %0d bytes, %0d strobes seen, %0d expected", tag, frame_q.size(), ev_q.size(), exp_q.size());
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] rdval;
        bit         exp_rd;
        bit         exp_wr;
        logic [6:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vt[5];

    initial begin
        int t;
        bit exp_rd1;

        vt[0] = '{8'h85, 8'h3C, 8'h00, 1'b0, 1'b1, 7'h05, 8'h3C, 8'h00};
        vt[1] = '{8'h12, 8'hFF, 8'hA7, 1'b1, 1'b0, 7'h12, 8'h00, 8'hA7};
        vt[2] = '{8'hFF, 8'h5A, 8'h00, 1'b0, 1'b1, 7'h7F, 8'h5A, 8'h00};
        vt[3] = '{8'h00, 8'h00, 8'h5C, 1'b1, 1'b0, 7'h00, 8'h00, 8'h5C};
        vt[4] = '{8'h7F, 8'h33, 8'hE1, 1'b1, 1'b0, 7'h7F, 8'h00, 8'hE1};

        for (int i = 0; i < 128; i++) regmem[i] = 8'($urandom);

        // Reset held for 3 clocks
        rst = 1'b1;
        gap(3);
        chk("reset_read", {31'd0, read}, 32'd0);
        chk("reset_write", {31'd0, write}, 32'd0);
        chk("reset_addr", {25'd0, addr}, 32'd0);
        chk("reset_dout", {24'd0, data_out}, 32'd0);
        chk("reset_wdata", {24'd0, data_write}, 32'd0);
        rst = 1'b0;
        gap(2);
        $display("reset: read=%0b write=%0b addr=%0h data_out=%0h", read, write, addr, data_out);

        // Table-driven 2-byte frames
        for (int v = 0; v < 5; v++) begin
`ifdef AUTO_INC_EN
            exp_rd1 = !vt[v].cmd[7];
`else
            exp_rd1 = 1'b0;
`endif
            regmem[vt[v].exp_addr] = vt[v].rdval;
            cs_n = 1'b0;
            gap(3);
            send_byte(vt[v].cmd, t);
            chk("vec_cmd_read", {31'd0, read}, {31'd0, vt[v].exp_rd});
            chk("vec_cmd_write", {31'd0, write}, 32'd0);
            if (vt[v].exp_rd) chk("vec_read_addr", {25'd0, addr}, {25'd0, vt[v].exp_addr});
            @(negedge clk);
            chk("vec_dout_t2", {24'd0, data_out}, {24'd0, vt[v].exp_dout});
            gap(5);
            send_byte(vt[v].dat, t);
            chk("vec_data_write", {31'd0, write}, {31'd0, vt[v].exp_wr});
            chk("vec_data_read", {31'd0, read}, {31'd0, exp_rd1});
            if (vt[v].exp_wr) begin
                chk("vec_write_addr", {25'd0, addr}, {25'd0, vt[v].exp_addr});
                chk("vec_write_data", {24'd0, data_write}, {24'd0, vt[v].exp_wdata});
            end
            gap(5);
            cs_n = 1'b1;
            gap(4);
            chk("vec_dout_clear", {24'd0, data_out}, 32'd0);
            $display("vector %0d: cmd=%02h dat=%02h read=%0b write=%0b addr=%02h", v, vt[v].cmd, vt[v].dat,
                     vt[v].exp_rd, vt[v].exp_wr, vt[v].exp_addr);
        end

        // Abort: write command, cs_n released, next byte is a fresh command
        frame_q = '{8'h81};
        run_frame("abort_cmd");
        gap(4);
        frame_q = '{8'h12, 8'hFF};
        run_frame("after_abort");

        // Back-to-back frames inside one cs_n-low window
        frame_q = '{8'h81, 8'h11, 8'h01, 8'h00};
        run_frame("back_to_back");

        // byte_sync while cs_n is high must be ignored
        ev_q.delete();
        gap(4);
        send_byte(8'h12, t);
        gap(4);
        chk("cs_high_ignored", ev_q.size(), 0);
        $display("cs_n high byte: %0d strobes", ev_q.size());

        // Reset coincident with a read command suppresses the strobe
        cs_n = 1'b0;
        gap(3);
        ev_q.delete();
        @(negedge clk);
        data_in   = 8'h12;
        byte_sync = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        byte_sync = 1'b0;
        chk("rst_suppress_read", {31'd0, read}, 32'd0);
        rst = 1'b0;
        gap(4);
        chk("rst_no_strobes", ev_q.size(), 0);
        cs_n = 1'b1;
        gap(4);
        $display("reset mid-command: %0d strobes", ev_q.size());

`ifdef AUTO_INC_EN
        frame_q = '{8'hFE, 8'hAA, 8'hBB, 8'hCC};
        run_frame("burst_wrap");
        if (ev_q.size() == 3) chk("burst_wrap_addr", ev_q[2].a, 0);
        frame_q = '{8'h7F, 8'h00, 8'h00};
        run_frame("burst_read_wrap");
`endif

        // Random frames against the reference model
        for (int f = 0; f < 20; f++) begin
            frame_q.delete();
            repeat ($urandom_range(1, 4)) frame_q.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
